// File: rtl/mac_pkg.sv
// Shared MAC datapath definitions: accumulate-stage width and operand word type.
package mac_pkg;

  localparam int ADDER_WIDTH = 8;

  typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage

// File: rtl/adder_8bit_full_adder.sv
// One-bit full adder; the ripple stage of adder_8bit.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p_s;

  assign p_s  = a ^ b;
  assign s    = p_s ^ cin;
  assign cout = (a & b) | (cin & p_s);

endmodule

// File: rtl/adder_8bit.sv
// Unsigned ripple-carry adder with a zero-latency sum and a one-cycle registered copy.
module adder_8bit
  import mac_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [WIDTH-1:0] sum_r,
  output logic             carry_out_r,
  output logic             out_valid
);

  logic [WIDTH:0] carry_s;

  // No carry-in: the chain starts from a constant zero.
  assign carry_s[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry_s[i]),
      .s    (sum[i]),
      .cout (carry_s[i+1])
    );
  end

  assign carry_out = carry_s[WIDTH];

  // Output register: captures the sum when in_valid, otherwise holds data and drops valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r       <= {WIDTH{1'b0}};
      carry_out_r <= 1'b0;
      out_valid   <= 1'b0;
    end else if (in_valid) begin
      sum_r       <= sum;
      carry_out_r <= carry_out;
      out_valid   <= 1'b1;
    end else begin
      sum_r       <= sum_r;
      carry_out_r <= carry_out_r;
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_8bit.sv
// Self-checking bench for adder_8bit: exhaustive combinational sweep, directed
// boundary/latency/reset steps and a randomized registered-path run.
module tb_adder_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_valid;
  logic [7:0] sum;
  logic       carry_out;
  logic [7:0] sum_r;
  logic       carry_out_r;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  // Reference state of the registered path
  logic [8:0] exp_reg;
  logic       exp_v;

  adder_8bit #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .in_valid    (in_valid),
    .sum         (sum),
    .carry_out   (carry_out),
    .sum_r       (sum_r),
    .carry_out_r (carry_out_r),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] add9(input int x, input int y);
    int t;
    t = x + y;
    return t[8:0];
  endfunction

  task automatic check_comb(input string tag, input int x, input int y);
    check(tag, {7'd0, carry_out, sum}, {7'd0, add9(x, y)});
  endtask

  task automatic check_reg(input string tag, input int s, input int c, input int v);
    check({tag, "_sum_r"}, {8'd0, sum_r}, 16'(s));
    check({tag, "_carry_r"}, {15'd0, carry_out_r}, 16'(c));
    check({tag, "_valid"}, {15'd0, out_valid}, 16'(v));
  endtask

  initial begin
    int sweep_err;
    int ra, rb, rv;

    rst = 1'b1; a = 8'd0; b = 8'd0; in_valid = 1'b0;
    #1;
    check_reg("reset", 0, 0, 0);
    check_comb("reset_comb", 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1. Exhaustive combinational sweep
    sweep_err = errors;
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 256; bi++) begin
        a = 8'(ai); b = 8'(bi);
        #1;
        check_comb("sweep", ai, bi);
      end
    end
    $display("sweep errors %0d", errors - sweep_err);

    // 2. Carry boundaries
    a = 8'd255; b = 8'd1;   #1; check("b_255_1",   {7'd0, carry_out, sum}, 16'd256);
    a = 8'd255; b = 8'd255; #1; check("b_255_255", {7'd0, carry_out, sum}, 16'd510);
    a = 8'd0;   b = 8'd0;   #1; check("b_0_0",     {7'd0, carry_out, sum}, 16'd0);
    a = 8'd127; b = 8'd128; #1; check("b_127_128", {7'd0, carry_out, sum}, 16'd255);
    a = 8'd128; b = 8'd128; #1; check("b_128_128", {7'd0, carry_out, sum}, 16'd256);
    check_reg("idle_after_sweep", 0, 0, 0);

    // 3. Registered latency
    @(negedge clk);
    a = 8'd100; b = 8'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    check_reg("lat_capture", 44, 1, 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_reg("lat_hold", 44, 1, 0);

    // 4. Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check_reg("async_rst", 0, 0, 0);
    check_comb("async_rst_comb", 100, 200);
    a = 8'd17; b = 8'd250;
    #1;
    check_comb("rst_comb_track", 17, 250);
    rst = 1'b0;

    // 5. Back-to-back captures
    @(negedge clk);
    in_valid = 1'b1; a = 8'd1; b = 8'd2;
    @(posedge clk); #1;
    check_reg("b2b_0", 3, 0, 1);
    a = 8'd250; b = 8'd10;
    @(posedge clk); #1;
    check_reg("b2b_1", 4, 1, 1);
    a = 8'd0; b = 8'd0;
    @(posedge clk); #1;
    check_reg("b2b_2", 0, 0, 1);
    in_valid = 1'b0;

    // Randomized registered path against the reference model
    exp_reg = 9'd0; exp_v = 1'b0;
    for (int i = 0; i < 80; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      rv = int'($urandom_range(0, 1));
      a = 8'(ra); b = 8'(rb); in_valid = rv[0];
      #1;
      check_comb("rand_comb", ra, rb);
      if (rv != 0) exp_reg = add9(ra, rb);
      exp_v = rv[0];
      @(posedge clk); #1;
      check_reg("rand_reg", int'(exp_reg[7:0]), int'(exp_reg[8]), int'(exp_v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
